// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream
//   Streaming KxK convolution engine. Pixels arrive in raster order; K-1
//   previous rows are kept in a line-buffer shift chain, a KxK window slides
//   over the image and is multiplied by a serially loaded weight set.
//   Results appear a fixed 2 cycles after the triggering pixel is accepted.
//
// Handshakes:
//   pixel_valid/pixel_ready: a pixel transfers on a rising edge where both
//   are 1. pixel_ready depends only on the FSM state, never on pixel_valid.
//   w_load_valid has no ready; a word is taken on every edge it is high,
//   except while streaming (ignored) or when a pixel is accepted in READY.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   w_in, w_load_valid  weight word stream, row-major (top-left first)
//   weights_ready       full weight set held
//   pixel_in/valid/ready pixel stream
//   result, result_valid result sum and its 1-cycle valid pulse
//   result_row/col      output-map coordinates of result
//   frame_done          pulse with the last result of a frame
//   fsm_state           current FSM state (IDLE=0, LOAD=1, READY=2, STREAM=3)
module conv_kxk_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ACC_W  = 2*DATA_W+4,
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_load_valid,
    output logic              weights_ready,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic [RW-1:0]     result_row,
    output logic [CW-1:0]     result_col,
    output logic              frame_done,
    output logic [1:0]        fsm_state
);

    localparam int NW     = K*K;
    localparam int IW     = $clog2(NW+1);
    localparam int SR_LEN = (K-1)*IMG_W;
    localparam int PW     = 2*DATA_W;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2, STREAM = 2'd3} state_t;
    state_t state, state_d;

    logic [DATA_W-1:0] wts [NW];
    logic [IW-1:0]     widx;
    logic [DATA_W-1:0] sr [SR_LEN];
    logic [DATA_W-1:0] win [NW];
    logic [DATA_W-1:0] col_in [K];
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              accept, w_write, col_wrap, last_pix;

    logic              win_valid, win_last;
    logic [RW-1:0]     win_row;
    logic [CW-1:0]     win_col;
    logic [PW-1:0]     prod [NW];
    logic              p_valid, p_last;
    logic [RW-1:0]     p_row;
    logic [CW-1:0]     p_col;
    logic [ACC_W-1:0]  sum;

    assign pixel_ready   = (state == READY) || (state == STREAM);
    assign weights_ready = pixel_ready;
    assign fsm_state     = state;
    assign accept        = pixel_valid && pixel_ready;
    assign col_wrap      = (col == CW'(IMG_W-1));
    assign last_pix      = col_wrap && (row == RW'(IMG_H-1));
    // In READY an accepted pixel takes priority over a reload request.
    assign w_write       = w_load_valid &&
                           ((state == IDLE) || (state == LOAD) || (state == READY && !accept));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (w_load_valid) state_d = LOAD;
            LOAD:    if (w_load_valid && widx == IW'(NW-1)) state_d = READY;
            READY: begin
                if (accept)            state_d = last_pix ? READY : STREAM;
                else if (w_load_valid) state_d = LOAD;
            end
            STREAM:  if (accept && last_pix) state_d = READY;
            default: state_d = IDLE;
        endcase
    end

    // Weight store: a write from IDLE or READY always restarts at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            widx <= '0;
            for (int i = 0; i < NW; i++) wts[i] <= '0;
        end else if (w_write) begin
            if (state == LOAD) begin
                wts[widx] <= w_in;
                widx      <= (widx == IW'(NW-1)) ? '0 : widx + 1'b1;
            end else begin
                wts[0] <= w_in;
                widx   <= IW'(1);
            end
        end
    end

    // New right-hand window column: row r comes from (K-1-r) image rows back.
    always_comb begin
        for (int r = 0; r < K-1; r++) col_in[r] = sr[(K-1-r)*IMG_W-1];
        col_in[K-1] = pixel_in;
    end

    // Line buffers, window and raster counters advance only on accepted pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SR_LEN; i++) sr[i] <= '0;
            for (int i = 0; i < NW; i++) win[i] <= '0;
            row       <= '0;
            col       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= 1'b0;
            if (accept) begin
                sr[0] <= pixel_in;
                for (int i = 1; i < SR_LEN; i++) sr[i] <= sr[i-1];
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K-1; c++) win[r*K+c] <= win[r*K+c+1];
                    win[r*K+K-1] <= col_in[r];
                end
                if (col_wrap) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H-1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                // Requiring col >= K-1 excludes windows straddling a row wrap.
                win_valid <= (row >= RW'(K-1)) && (col >= CW'(K-1));
                win_last  <= last_pix;
                win_row   <= row - RW'(K-1);
                win_col   <= col - CW'(K-1);
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NW; i++) sum = sum + ACC_W'(prod[i]);
    end

    // Product and sum stages run every cycle; the valid tag rides along.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) prod[i] <= '0;
            p_valid      <= 1'b0;
            p_last       <= 1'b0;
            p_row        <= '0;
            p_col        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            result_row   <= '0;
            result_col   <= '0;
            frame_done   <= 1'b0;
        end else begin
            for (int i = 0; i < NW; i++) prod[i] <= PW'(wts[i]) * PW'(win[i]);
            p_valid      <= win_valid;
            p_last       <= win_valid && win_last;
            p_row        <= win_row;
            p_col        <= win_col;
            result_valid <= p_valid;
            frame_done   <= p_last;
            if (p_valid) begin
                result     <= sum;
                result_row <= p_row;
                result_col <= p_col;
            end
        end
    end

endmodule

// File: tb/tb_conv_kxk_stream.sv
module tb_conv_kxk_stream;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int K      = 3;
  localparam int ACC_W  = 2*DATA_W+4;
  localparam int RW     = $clog2(IMG_H);
  localparam int CW     = $clog2(IMG_W);
  localparam int NW     = K*K;
  localparam int NPIX   = IMG_W*IMG_H;
  localparam int OW     = IMG_W-K+1;
  localparam int OH     = IMG_H-K+1;
  localparam int PKW    = 1+RW+CW+ACC_W;

  // clock / reset block
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] w_in;
  logic              w_load_valid;
  logic              weights_ready;
  logic [DATA_W-1:0] pixel_in;
  logic              pixel_valid;
  logic              pixel_ready;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic [RW-1:0]     result_row;
  logic [CW-1:0]     result_col;
  logic              frame_done;
  logic [1:0]        fsm_state;

  conv_kxk_stream #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .w_in(w_in), .w_load_valid(w_load_valid),
    .weights_ready(weights_ready), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .result(result), .result_valid(result_valid),
    .result_row(result_row), .result_col(result_col), .frame_done(frame_done),
    .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] img [NPIX];
  logic [DATA_W-1:0] wts_m [NW];
  int                acc_cyc [NPIX];

  // scoreboard: expected results (packed {frame_done,row,col,result}) and cycles
  logic [PKW-1:0] exp_q[$];
  int             exp_t[$];
  logic [PKW-1:0] got_q[$];
  int             got_t[$];

  always @(negedge clk) begin
    if (result_valid) begin
      got_q.push_back({frame_done, result_row, result_col, result});
      got_t.push_back(cyc);
    end
  end

  // Reference: direct sum over each in-frame KxK window of the stored image.
  function automatic void build_exp();
    int s;
    exp_q.delete();
    exp_t.delete();
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c++) begin
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += int'(wts_m[i*K+j]) * int'(img[(r+i)*IMG_W+c+j]);
        exp_q.push_back({(r == OH-1 && c == OW-1) ? 1'b1 : 1'b0, RW'(r), CW'(c), ACC_W'(s)});
        exp_t.push_back(acc_cyc[(r+K-1)*IMG_W+c+K-1] + 2);
      end
    end
  endfunction

  // driver tasks
  task automatic load_weights(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w_in         = wts_m[start+i];
      w_load_valid = 1'b1;
      pixel_valid  = 1'b0;
    end
    @(negedge clk);
    w_load_valid = 1'b0;
  endtask

  task automatic drive_frame(input bit stall, input bit noise, input int npix, output bit ok);
    int idx = 0;
    int guard = 0;
    ok = 1'b1;
    while (idx < npix) begin
      @(negedge clk);
      pixel_valid  = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      pixel_in     = img[idx];
      w_load_valid = noise && idx > 0 && ($urandom_range(0, 1) == 1);
      w_in         = DATA_W'($urandom);
      if (pixel_valid && pixel_ready) begin
        acc_cyc[idx] = cyc + 1;
        idx++;
      end
      guard++;
      if (guard > 2000) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    pixel_valid  = 1'b0;
    w_load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    w_in = '0; w_load_valid = 1'b0; pixel_in = '0; pixel_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({result, result_valid, result_row, result_col, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%b/%0d/%0d/%b required 0", result, result_valid, result_row, result_col, frame_done);
    end
    checks++;
    if (weights_ready !== 1'b0 || pixel_ready !== 1'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got wr=%b pr=%b st=%0d required 0/0/0", weights_ready, pixel_ready, fsm_state);
    end
  endtask

  task automatic test_ones_frame();
    bit ok;
    for (int i = 0; i < NW; i++) wts_m[i] = 1;
    for (int i = 0; i < NPIX; i++) img[i] = DATA_W'(i);
    load_weights(NW-1, 0);
    checks++;
    if (weights_ready !== 1'b0 || fsm_state !== 2'd1) begin
      errors++;
      $display("FAIL partial_load got wr=%b st=%0d required 0/1", weights_ready, fsm_state);
    end
    load_weights(1, NW-1);
    checks++;
    if (weights_ready !== 1'b1 || pixel_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_done got wr=%b pr=%b required 1/1", weights_ready, pixel_ready);
    end
    got_q.delete(); got_t.delete();
    drive_frame(1'b0, 1'b0, NPIX, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL ones_timeout got stalled required accept"); end
    build_exp();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != 36) begin
      errors++;
      $display("FAIL ones_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
        errors++;
        $display("FAIL ones_result[%0d] got %h@%0d required %h@%0d", i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
      end
    end
    if (got_q.size() == 36) begin
      checks++;
      if (got_q[0] !== {1'b0, RW'(0), CW'(0), ACC_W'(81)} || got_t[0] != acc_cyc[18] + 2) begin
        errors++;
        $display("FAIL ones_first got %h@%0d required 81 at (0,0)@%0d", got_q[0], got_t[0], acc_cyc[18] + 2);
      end
      checks++;
      if (got_q[35] !== {1'b1, RW'(5), CW'(5), ACC_W'(486)}) begin
        errors++;
        $display("FAIL ones_last got %h required 486 at (5,5) with frame_done", got_q[35]);
      end
    end
  endtask

  task automatic test_center();
    bit ok;
    logic [PKW-1:0] g;
    int r, c;
    for (int i = 0; i < NW; i++) wts_m[i] = (i == 4) ? 1 : 0;
    for (int i = 0; i < NPIX; i++) img[i] = DATA_W'(i);
    load_weights(NW, 0);
    got_q.delete(); got_t.delete();
    drive_frame(1'b0, 1'b0, NPIX, ok);
    repeat (4) @(negedge clk);
    build_exp();
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL center_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      g = got_q[i];
      r = int'(g[ACC_W+CW+RW-1:ACC_W+CW]);
      c = int'(g[ACC_W+CW-1:ACC_W]);
      checks++;
      if (g !== exp_q[i] || int'(g[ACC_W-1:0]) != 8*(r+1)+(c+1)) begin
        errors++;
        $display("FAIL center_result[%0d] got %h required %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_max();
    bit ok;
    logic [PKW-1:0] g;
    for (int i = 0; i < NW; i++) wts_m[i] = 8'd255;
    for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
    load_weights(NW, 0);
    got_q.delete(); got_t.delete();
    drive_frame(1'b0, 1'b0, NPIX, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || got_q.size() != OH*OW) begin
      errors++;
      $display("FAIL max_count got %0d required %0d", got_q.size(), OH*OW);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      g = got_q[i];
      checks++;
      if (g[ACC_W-1:0] !== ACC_W'(585225)) begin
        errors++;
        $display("FAIL max_result[%0d] got %0d required 585225", i, g[ACC_W-1:0]);
      end
    end
  endtask

  task automatic test_stalls();
    bit ok;
    for (int i = 0; i < NW; i++) wts_m[i] = DATA_W'($urandom);
    for (int i = 0; i < NPIX; i++) img[i] = DATA_W'($urandom);
    load_weights(NW, 0);
    got_q.delete(); got_t.delete();
    drive_frame(1'b1, 1'b0, NPIX, ok);
    repeat (4) @(negedge clk);
    build_exp();
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
        errors++;
        $display("FAIL stall_result[%0d] got %h@%0d required %h@%0d", i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_reload();
    bit ok;
    int ready_seen = 0;
    for (int i = 0; i < NW; i++) wts_m[i] = DATA_W'($urandom);
    for (int i = 0; i < NPIX; i++) img[i] = DATA_W'($urandom);
    load_weights(5, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_in    = DATA_W'($urandom);
      if (pixel_ready !== 1'b0 || weights_ready !== 1'b0) ready_seen++;
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    checks++;
    if (ready_seen != 0) begin
      errors++;
      $display("FAIL reload_block got %0d ready cycles required 0", ready_seen);
    end
    load_weights(NW-5, 5);
    checks++;
    if (pixel_ready !== 1'b1 || weights_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_done got pr=%b wr=%b required 1/1", pixel_ready, weights_ready);
    end
    got_q.delete(); got_t.delete();
    drive_frame(1'b1, 1'b1, NPIX, ok);
    repeat (4) @(negedge clk);
    build_exp();
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reload_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
        errors++;
        $display("FAIL reload_result[%0d] got %h@%0d required %h@%0d", i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    for (int i = 0; i < NPIX; i++) img[i] = DATA_W'($urandom);
    drive_frame(1'b0, 1'b0, 30, ok);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({result, result_valid, result_row, result_col, frame_done, weights_ready, pixel_ready} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %h/%b/%0d/%0d/%b/%b/%b required 0", result, result_valid,
               result_row, result_col, frame_done, weights_ready, pixel_ready);
    end
    rst = 1'b0;
    got_q.delete(); got_t.delete();
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_drain got %0d results required 0", got_q.size());
    end
    for (int i = 0; i < NW; i++) wts_m[i] = DATA_W'($urandom);
    for (int i = 0; i < NPIX; i++) img[i] = DATA_W'($urandom);
    load_weights(NW, 0);
    got_q.delete(); got_t.delete();
    drive_frame(1'b0, 1'b0, NPIX, ok);
    repeat (4) @(negedge clk);
    build_exp();
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midreset_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
        errors++;
        $display("FAIL midreset_result[%0d] got %h@%0d required %h@%0d", i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones_frame();
    test_center();
    test_max();
    test_stalls();
    test_reload();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
